fp_result_buffer: RTL and testbench

FP_RESULT_BUFFER -- requirements
Module: fp_result_buffer

---
 rtl/fp_result_buffer.sv | 155 +++++++++++++++
 tb/tb_fp_result_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_buffer.sv
// fp_result_buffer: in-order circular FIFO that holds FP unit results until
// the common data bus grants them. The head entry is presented combinationally
// and held stable until granted. ce_o stalls the unit early enough that the
// result already registered inside it always has a free slot.
// Optional feature macro: FPRB_BYPASS_EN. When it is defined, a result that
// arrives while the buffer is empty is offered on the bus in the same cycle.
module fp_result_buffer #(
  parameter int FPWID = 80,
  parameter int TAGW  = 6,
  parameter int EXCW  = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  // Result from the upstream FP unit
  input  logic             v_i,
  input  logic [TAGW-1:0]  tag_i,
  input  logic [FPWID+3:0] o_i,
  input  logic             zero_i,
  input  logic             inf_i,
  input  logic             pos_i,
  input  logic             neg_i,
  input  logic [EXCW-1:0]  exc_i,
  output logic             ce_o,
  // Control
  input  logic             flush,
  input  logic             clr_exc,
  // Common data bus side
  output logic             cdb_req,
  input  logic             cdb_gnt,
  output logic [TAGW-1:0]  cdb_tag,
  output logic [FPWID+3:0] cdb_res,
  output logic             cdb_zero,
  output logic             cdb_inf,
  output logic             cdb_pos,
  output logic             cdb_neg,
  output logic [EXCW-1:0]  cdb_exc,
  // Sticky status
  output logic             ovf_err,
  output logic             exc_sticky
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAGW-1:0]  tag;
    logic [FPWID+3:0] res;
    logic             zero;
    logic             inf;
    logic             pos;
    logic             neg;
    logic [EXCW-1:0]  exc;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf_err;
  logic          r_exc_sticky;

  entry_t w_in;
  entry_t w_head;
  entry_t w_out;
  logic   w_empty;
  logic   w_full;
  logic   w_req;
  logic   w_byp_take;
  logic   w_pop_fifo;
  logic   w_push;
  logic   w_drop;
  logic   w_deliver;

  assign w_in = '{tag: tag_i, res: o_i, zero: zero_i, inf: inf_i,
                  pos: pos_i, neg: neg_i, exc: exc_i};

  assign w_head  = r_mem[r_rptr];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Select what the bus sees: the stored head, or the live input when bypassing.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_out      = w_head;
    w_req      = !w_empty;
    w_byp_take = 1'b0;
`ifdef FPRB_BYPASS_EN
    if (w_empty && v_i) begin
      w_out      = w_in;
      w_req      = 1'b1;
      w_byp_take = cdb_gnt;
    end
`endif
  end

  // A grant only removes a stored entry when one exists; a bypassed result
  // granted in its arrival cycle is consumed and never written.
  assign w_pop_fifo = !w_empty && cdb_gnt;
  assign w_push     = v_i && !w_byp_take && (!w_full || w_pop_fifo);
  assign w_drop     = v_i && w_full && !w_pop_fifo;
  assign w_deliver  = w_req && cdb_gnt;

  assign cdb_req    = w_req;
  assign cdb_tag    = w_out.tag;
  assign cdb_res    = w_out.res;
  assign cdb_zero   = w_out.zero;
  assign cdb_inf    = w_out.inf;
  assign cdb_pos    = w_out.pos;
  assign cdb_neg    = w_out.neg;
  assign cdb_exc    = w_out.exc;

  // Keep one slot free for the result already in flight inside the unit.
  assign ce_o       = (r_count <= CW'(DEPTH - 2));

  assign ovf_err    = r_ovf_err;
  assign exc_sticky = r_exc_sticky;

  // Pointer and occupancy bookkeeping; flush empties the FIFO and drops this cycle's push/pop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)     r_wptr <= r_wptr + 1'b1;
      if (w_pop_fifo) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop_fifo)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop_fifo) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage write.
  // NOTE: storage is deliberately not reset; entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_in;
  end

  // Sticky flags: clear first, then a same-cycle set event overrides the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_err    <= 1'b0;
      r_exc_sticky <= 1'b0;
    end else begin
      if (clr_exc) begin
        r_ovf_err    <= 1'b0;
        r_exc_sticky <= 1'b0;
      end
      if (w_drop) r_ovf_err <= 1'b1;
      if (w_deliver && !flush && (w_out.exc != '0)) r_exc_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_result_buffer.sv
// Self-checking bench for fp_result_buffer. A queue-based reference model
// tracks buffer contents and sticky flags; a negedge process compares every
// DUT output against it, and directed sequences add hand-computed checks.
// Build with +define+FPRB_BYPASS_EN to also exercise the bypass path.
module tb_fp_result_buffer;

  localparam int FPWID = 80;
  localparam int TAGW  = 6;
  localparam int EXCW  = 8;
  localparam int DEPTH = 4;
  localparam logic [FPWID+3:0] ONE = {4'h0, 80'h3FFF_8000_0000_0000_0000};

  logic             clk = 1'b0;
  logic             rst;
  logic             v_i;
  logic [TAGW-1:0]  tag_i;
  logic [FPWID+3:0] o_i;
  logic             zero_i, inf_i, pos_i, neg_i;
  logic [EXCW-1:0]  exc_i;
  logic             ce_o;
  logic             flush;
  logic             clr_exc;
  logic             cdb_req;
  logic             cdb_gnt;
  logic [TAGW-1:0]  cdb_tag;
  logic [FPWID+3:0] cdb_res;
  logic             cdb_zero, cdb_inf, cdb_pos, cdb_neg;
  logic [EXCW-1:0]  cdb_exc;
  logic             ovf_err;
  logic             exc_sticky;

  always #5 clk = ~clk;

  fp_result_buffer #(.FPWID(FPWID), .TAGW(TAGW), .EXCW(EXCW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .v_i(v_i), .tag_i(tag_i), .o_i(o_i),
    .zero_i(zero_i), .inf_i(inf_i), .pos_i(pos_i), .neg_i(neg_i), .exc_i(exc_i),
    .ce_o(ce_o), .flush(flush), .clr_exc(clr_exc),
    .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_tag(cdb_tag), .cdb_res(cdb_res),
    .cdb_zero(cdb_zero), .cdb_inf(cdb_inf), .cdb_pos(cdb_pos), .cdb_neg(cdb_neg),
    .cdb_exc(cdb_exc), .ovf_err(ovf_err), .exc_sticky(exc_sticky)
  );

  typedef struct packed {
    logic [TAGW-1:0]  tag;
    logic [FPWID+3:0] res;
    logic             zero;
    logic             inf;
    logic             pos;
    logic             neg;
    logic [EXCW-1:0]  exc;
  } ent_t;

  // Reference model state
  ent_t mq[$];
  logic m_ovf = 1'b0;
  logic m_exc = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t cur_in();
    ent_t e;
    e = '{tag: tag_i, res: o_i, zero: zero_i, inf: inf_i, pos: pos_i, neg: neg_i, exc: exc_i};
    return e;
  endfunction

  // Bus request the model expects in the current cycle
  function automatic logic m_req();
    logic r;
    r = (mq.size() != 0);
`ifdef FPRB_BYPASS_EN
    if (mq.size() == 0 && v_i) r = 1'b1;
`endif
    return r;
  endfunction

  // What the model expects on the bus: oldest stored result, else the live input
  function automatic ent_t m_head();
    if (mq.size() != 0) return mq[0];
    return cur_in();
  endfunction

  // Model update at each rising edge from the inputs held stable across it
  always @(posedge clk) begin
    bit   pop;
    bit   byp;
    bit   push;
    bit   drop;
    ent_t d;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_exc = 1'b0;
    end else begin
      d    = m_head();
      pop  = m_req() && cdb_gnt;
      byp  = pop && (mq.size() == 0);
      push = v_i && !byp && ((mq.size() < DEPTH) || pop);
      drop = v_i && (mq.size() == DEPTH) && !pop;
      if (clr_exc) begin
        m_ovf = 1'b0;
        m_exc = 1'b0;
      end
      if (drop) m_ovf = 1'b1;
      if (pop && !flush && d.exc != '0) m_exc = 1'b1;
      if (flush) mq.delete();
      else begin
        if (pop && !byp) void'(mq.pop_front());
        if (push) mq.push_back(cur_in());
      end
    end
  end

  // Compare every DUT output against the model on the falling edge
  always @(negedge clk) begin
    ent_t act;
    ent_t exp_e;
    if (cmp_en) begin
      check("cdb_req", 128'(cdb_req), 128'(m_req()));
      check("ce_o", 128'(ce_o), 128'(mq.size() <= DEPTH - 2));
      check("ovf_err", 128'(ovf_err), 128'(m_ovf));
      check("exc_sticky", 128'(exc_sticky), 128'(m_exc));
      if (m_req()) begin
        act   = '{tag: cdb_tag, res: cdb_res, zero: cdb_zero, inf: cdb_inf,
                  pos: cdb_pos, neg: cdb_neg, exc: cdb_exc};
        exp_e = m_head();
        check("cdb_fields", 128'(act), 128'(exp_e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v_i     = 1'b0;
    flush   = 1'b0;
    clr_exc = 1'b0;
  endtask

  task automatic set_in(input int tag, input int exc);
    v_i   = 1'b1;
    tag_i = TAGW'(tag);
    o_i   = ONE ^ (FPWID + 4)'(tag);
    {zero_i, inf_i, pos_i, neg_i} = 4'(tag);
    exc_i = EXCW'(exc);
  endtask

  task automatic fill(input int first, input int n);
    for (int t = 0; t < n; t++) begin
      set_in(first + t, 0);
      step();
    end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got [4];
    rst = 1'b1; cdb_gnt = 1'b0;
    v_i = 1'b0; flush = 1'b0; clr_exc = 1'b0;
    tag_i = '0; o_i = '0; exc_i = '0;
    {zero_i, inf_i, pos_i, neg_i} = 4'h0;
    step(); step();
    cmp_en = 1'b1;
    check("rst_req", 128'(cdb_req), 128'(0));
    check("rst_ce", 128'(ce_o), 128'(1));
    rst = 1'b0;

    // Single push of 1.0 with tag 5, grant held high
    cdb_gnt = 1'b1;
    set_in(5, 0);
    o_i = ONE;
`ifndef FPRB_BYPASS_EN
    #1 check("single_req_same_cycle", 128'(cdb_req), 128'(0));
    step(); idle();
    check("single_req", 128'(cdb_req), 128'(1));
    check("single_tag", 128'(cdb_tag), 128'(5));
    check("single_res", 128'(cdb_res), 128'(ONE));
    step();
    check("single_drained", 128'(cdb_req), 128'(0));
    check("single_m_count", 128'(mq.size()), 128'(0));
`else
    step(); idle();
`endif
    cdb_gnt = 1'b0;
    step();

    // Fill to DEPTH without grant, then overflow and drain in order
    fill(1, 3);
    check("fill3_ce", 128'(ce_o), 128'(0));
    check("fill3_m_count", 128'(mq.size()), 128'(3));
    fill(4, 1);
    set_in(5, 0);
    step(); idle();
    check("ovf_set", 128'(ovf_err), 128'(1));
    check("ovf_m_count", 128'(mq.size()), 128'(4));
    cdb_gnt = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_order", 128'(cdb_tag), 128'(k));
      step();
    end
    cdb_gnt = 1'b0;
    check("drain_empty", 128'(cdb_req), 128'(0));
    clr_exc = 1'b1;
    step(); idle();
    check("ovf_cleared", 128'(ovf_err), 128'(0));

    // Full buffer with simultaneous push and pop
    fill(1, 4);
    set_in(9, 0);
    cdb_gnt = 1'b1;
    #1 check("fullpp_head", 128'(cdb_tag), 128'(1));
    step(); idle();
    cdb_gnt = 1'b0;
    #1;
    check("fullpp_m_count", 128'(mq.size()), 128'(4));
    check("fullpp_no_ovf", 128'(ovf_err), 128'(0));
    check("fullpp_ce", 128'(ce_o), 128'(0));
    cdb_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got[k] = int'(cdb_tag);
      step();
    end
    cdb_gnt = 1'b0;
    check("fullpp_first", 128'(got[0]), 128'(2));
    check("fullpp_last", 128'(got[3]), 128'(9));

    // Flush with three entries, push and grant in the same cycle
    fill(1, 3);
    flush = 1'b1;
    set_in(6, 0);
    cdb_gnt = 1'b1;
    step(); idle();
    cdb_gnt = 1'b0;
    #1;
    check("flush_req", 128'(cdb_req), 128'(0));
    check("flush_ce", 128'(ce_o), 128'(1));

    // Reset in the middle of a drain
    fill(1, 3);
    cdb_gnt = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cdb_gnt = 1'b0;
    #1;
    check("rstmid_req", 128'(cdb_req), 128'(0));
    check("rstmid_ce", 128'(ce_o), 128'(1));

    // Exception sticky: set, then clear racing a new set event
    set_in(10, 2); step();
    set_in(11, 3); step();
    idle();
    cdb_gnt = 1'b1;
    step();
    check("exc_set", 128'(exc_sticky), 128'(1));
    clr_exc = 1'b1;
    step(); idle();
    cdb_gnt = 1'b0;
    #1 check("exc_set_wins", 128'(exc_sticky), 128'(1));
    clr_exc = 1'b1;
    step(); idle();
    check("exc_clear", 128'(exc_sticky), 128'(0));

    // Mixed traffic to wrap the pointers several times
    for (int i = 0; i < 24; i++) begin
      if (i % 3 != 2) set_in(20 + (i % 40), (i % 5 == 0) ? 1 : 0);
      else v_i = 1'b0;
      cdb_gnt = (i % 4 != 0);
      step();
    end
    idle();
    cdb_gnt = 1'b1;
    for (int i = 0; i < 6; i++) step();
    cdb_gnt = 1'b0;
    check("wrap_empty", 128'(cdb_req), 128'(0));
    clr_exc = 1'b1;
    step(); idle();

`ifdef FPRB_BYPASS_EN
    // Same-cycle bypass on an empty buffer
    cdb_gnt = 1'b1;
    set_in(7, 0);
    #1;
    check("byp_req", 128'(cdb_req), 128'(1));
    check("byp_tag", 128'(cdb_tag), 128'(7));
    step(); idle();
    cdb_gnt = 1'b0;
    #1;
    check("byp_m_count", 128'(mq.size()), 128'(0));
    check("byp_req_after", 128'(cdb_req), 128'(0));
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
